// File: rtl/cache_lookup_plru.sv
// ============================================================================
// Module   : cache_lookup_plru
// Purpose  : Set-associative tag lookup with per-set tree pseudo-LRU
//            replacement, back-to-back lookups and a multi-cycle history flush.
// Options  : LOOKUP_MULTIHIT_CHK_EN enables the multiple-match detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_lookup_plru #(
  parameter int TAG_WIDTH = 3,
  parameter int SET_WIDTH = 3,
  parameter int NUM_WAYS  = 4,
  localparam int WAY_IDX_W = $clog2(NUM_WAYS)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              i_lookup_req,
  input  logic [TAG_WIDTH-1:0]              i_addr_tag,
  input  logic [SET_WIDTH-1:0]              i_addr_set,
  input  logic [NUM_WAYS*(TAG_WIDTH+1)-1:0] i_addr_tag_store,
  input  logic                              i_flush,
  output logic                              o_lookup_valid,
  output logic                              o_hit,
  output logic [NUM_WAYS-1:0]               o_way_select,
  output logic [WAY_IDX_W-1:0]              o_way_idx,
  output logic                              o_busy,
  output logic                              o_multi_hit
);

  localparam int                 NUM_SETS = 1 << SET_WIDTH;
  localparam logic [SET_WIDTH-1:0] LAST_SET = SET_WIDTH'(NUM_SETS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                 state;
  logic [SET_WIDTH-1:0]   flush_cnt;
  logic [NUM_WAYS-2:0]    hist [NUM_SETS];

  logic                   lookup_valid_q;
  logic                   hit_q;
  logic [NUM_WAYS-1:0]    way_select_q;
  logic [WAY_IDX_W-1:0]   way_idx_q;
  logic                   busy_q;

  logic [NUM_WAYS-1:0]    match;
  logic [NUM_WAYS-1:0]    invalid;
  logic                   hit_any;
  logic                   free_any;
  logic [WAY_IDX_W-1:0]   hit_idx;
  logic [WAY_IDX_W-1:0]   free_idx;
  logic [WAY_IDX_W-1:0]   victim_idx;
  logic [WAY_IDX_W-1:0]   sel_idx;
  logic [NUM_WAYS-1:0]    sel_onehot;
  logic [NUM_WAYS-2:0]    hist_row;
  logic [NUM_WAYS-2:0]    new_row;
  int                     walk_node;
  int                     upd_node;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic [TAG_WIDTH:0] entry;
    assign entry      = i_addr_tag_store[w*(TAG_WIDTH+1) +: TAG_WIDTH+1];
    assign match[w]   = entry[TAG_WIDTH] && (entry[TAG_WIDTH-1:0] == i_addr_tag);
    assign invalid[w] = ~entry[TAG_WIDTH];
  end

  // Downward loops so the lowest matching / free index wins.
  always_comb begin
    hit_any  = |match;
    free_any = |invalid;
    hit_idx  = '0;
    free_idx = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (match[w])   hit_idx  = WAY_IDX_W'(w);
      if (invalid[w]) free_idx = WAY_IDX_W'(w);
    end
  end

  // Walk the heap-ordered tree: a 0 bit steers left, a 1 bit steers right.
  always_comb begin
    hist_row   = hist[i_addr_set];
    victim_idx = '0;
    walk_node  = 0;
    for (int d = 0; d < WAY_IDX_W; d++) begin
      victim_idx[WAY_IDX_W-1-d] = hist_row[walk_node[WAY_IDX_W-1:0]];
      walk_node = 2 * walk_node + 1 + int'(hist_row[walk_node[WAY_IDX_W-1:0]]);
    end
  end

  always_comb begin
    sel_idx    = hit_any ? hit_idx : (free_any ? free_idx : victim_idx);
    sel_onehot = NUM_WAYS'(1) << sel_idx;
  end

  // Each node on the selected path is turned to point at the other subtree.
  always_comb begin
    new_row  = hist_row;
    upd_node = 0;
    for (int d = 0; d < WAY_IDX_W; d++) begin
      new_row[upd_node[WAY_IDX_W-1:0]] = ~sel_idx[WAY_IDX_W-1-d];
      upd_node = 2 * upd_node + 1 + int'(sel_idx[WAY_IDX_W-1-d]);
    end
  end

`ifdef LOOKUP_MULTIHIT_CHK_EN
  logic [WAY_IDX_W:0] match_cnt;
  logic               multi_hit_q;

  always_comb begin
    match_cnt = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      match_cnt = match_cnt + {{WAY_IDX_W{1'b0}}, match[w]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      multi_hit_q <= 1'b0;
    end else begin
      multi_hit_q <= (state == IDLE) && i_lookup_req && (match_cnt > 1);
    end
  end

  assign o_multi_hit = multi_hit_q;
`else
  assign o_multi_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      lookup_valid_q <= 1'b0;
      hit_q          <= 1'b0;
      way_select_q   <= '0;
      way_idx_q      <= '0;
      busy_q         <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++) begin
        hist[s] <= '0;
      end
    end else begin
      lookup_valid_q <= 1'b0;
      hit_q          <= 1'b0;
      case (state)
        IDLE: begin
          if (i_lookup_req) begin
            lookup_valid_q   <= 1'b1;
            hit_q            <= hit_any;
            way_select_q     <= sel_onehot;
            way_idx_q        <= sel_idx;
            hist[i_addr_set] <= new_row;
          end
          if (i_flush) begin
            state     <= FLUSH;
            flush_cnt <= '0;
            busy_q    <= 1'b1;
          end
        end
        FLUSH: begin
          hist[flush_cnt] <= '0;
          if (flush_cnt == LAST_SET) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt + SET_WIDTH'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_lookup_valid = lookup_valid_q;
  assign o_hit          = hit_q;
  assign o_way_select   = way_select_q;
  assign o_way_idx      = way_idx_q;
  assign o_busy         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_lookup_plru.sv
// ============================================================================
// Module   : tb_cache_lookup_plru
// Purpose  : Directed self-checking bench for cache_lookup_plru (4 ways).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_lookup_plru;

  localparam int TW = 3;
  localparam int SW = 3;
  localparam int NW = 4;
  localparam int WI = 2;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              lookup_req;
  logic [TW-1:0]     addr_tag;
  logic [SW-1:0]     addr_set;
  logic [NW*(TW+1)-1:0] tag_store;
  logic              flush;
  logic              lookup_valid;
  logic              hit;
  logic [NW-1:0]     way_select;
  logic [WI-1:0]     way_idx;
  logic              busy;
  logic              multi_hit;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cache_lookup_plru #(.TAG_WIDTH(TW), .SET_WIDTH(SW), .NUM_WAYS(NW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_lookup_req     (lookup_req),
    .i_addr_tag       (addr_tag),
    .i_addr_set       (addr_set),
    .i_addr_tag_store (tag_store),
    .i_flush          (flush),
    .o_lookup_valid   (lookup_valid),
    .o_hit            (hit),
    .o_way_select     (way_select),
    .o_way_idx        (way_idx),
    .o_busy           (busy),
    .o_multi_hit      (multi_hit)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [NW*(TW+1)-1:0] store(input logic [3:0] w3, input logic [3:0] w2,
                                                  input logic [3:0] w1, input logic [3:0] w0);
    return {w3, w2, w1, w0};
  endfunction

  task automatic drive(input logic req, input logic [TW-1:0] tag, input logic [SW-1:0] set,
                       input logic [NW*(TW+1)-1:0] st, input logic fl);
    lookup_req = req;
    addr_tag   = tag;
    addr_set   = set;
    tag_store  = st;
    flush      = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input string tag, input logic exp_hit, input int exp_idx);
    check({tag, "_valid"}, 32'(lookup_valid), 32'd1);
    check({tag, "_hit"},   32'(hit),          32'(exp_hit));
    check({tag, "_idx"},   32'(way_idx),      32'(exp_idx));
    check({tag, "_sel"},   32'(way_select),   32'(1) << exp_idx);
  endtask

  logic [NW*(TW+1)-1:0] allv;
  int seq_exp [5] = '{0, 2, 1, 3, 0};

  initial begin
    allv = store({1'b1, 3'd4}, {1'b1, 3'd3}, {1'b1, 3'd2}, {1'b1, 3'd1});
    reset_n = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(lookup_valid), 32'd0);
    check("rst_hit",   32'(hit),          32'd0);
    check("rst_sel",   32'(way_select),   32'd0);
    check("rst_idx",   32'(way_idx),      32'd0);
    check("rst_busy",  32'(busy),         32'd0);
    check("rst_multi", 32'(multi_hit),    32'd0);
    reset_n = 1'b1;
    step();

    // Back-to-back misses on set 0: PLRU rotation 0,2,1,3,0
    drive(1'b1, 3'd5, 3'd0, allv, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 4) drive(1'b0, 3'd5, 3'd0, allv, 1'b0);
      expect_result($sformatf("b2b%0d", i), 1'b0, seq_exp[i]);
    end
    step();
    check("hold_valid", 32'(lookup_valid), 32'd0);
    check("hold_idx",   32'(way_idx),      32'd0);

    // Invalid way takes priority over the victim, then a hit on way 3
    drive(1'b1, 3'd7, 3'd1, store({1'b1, 3'd4}, {1'b0, 3'd3}, {1'b1, 3'd2}, {1'b1, 3'd1}), 1'b0);
    step();
    expect_result("free2", 1'b0, 2);
    drive(1'b1, 3'd4, 3'd1, allv, 1'b0);
    step();
    expect_result("hit3", 1'b1, 3);
    drive(1'b1, 3'd5, 3'd1, allv, 1'b0);
    step();
    expect_result("after_hit3", 1'b0, 0);

    // Hit on way 0 must also update history; set 0 untouched by set 1/2 traffic
    drive(1'b1, 3'd1, 3'd2, allv, 1'b0);
    step();
    expect_result("hit0", 1'b1, 0);
    drive(1'b1, 3'd5, 3'd2, allv, 1'b0);
    step();
    expect_result("after_hit0", 1'b0, 2);
    drive(1'b1, 3'd5, 3'd0, allv, 1'b0);
    step();
    expect_result("set0_iso", 1'b0, 2);

    // Populate remaining sets
    for (int s = 3; s < 8; s++) begin
      drive(1'b1, 3'd5, 3'(s), allv, 1'b0);
      step();
    end

    // Flush: busy for 8 cycles, lookups dropped
    drive(1'b0, 3'd5, 3'd0, allv, 1'b1);
    step();
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 3'd5, 3'd0, allv, 1'b0);
      check($sformatf("flush_busy%0d", k), 32'(busy), 32'd1);
      check($sformatf("flush_drop%0d", k), 32'(lookup_valid), 32'd0);
      step();
    end
    check("flush_done", 32'(busy), 32'd0);
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, 3'd5, 3'(s), allv, 1'b0);
      step();
      expect_result($sformatf("postflush%0d", s), 1'b0, 0);
    end

    // Lookup and flush in the same cycle
    drive(1'b1, 3'd5, 3'd3, allv, 1'b1);
    step();
    drive(1'b0, 3'd5, 3'd3, allv, 1'b0);
    expect_result("lkflush", 1'b0, 2);
    check("lkflush_busy", 32'(busy), 32'd1);
    repeat (8) step();
    check("lkflush_done", 32'(busy), 32'd0);
    drive(1'b1, 3'd5, 3'd3, allv, 1'b0);
    step();
    expect_result("lkflush_set3", 1'b0, 0);

    // Multiple matching ways
    drive(1'b1, 3'd6, 3'd4, store({1'b1, 3'd6}, {1'b1, 3'd2}, {1'b1, 3'd6}, {1'b1, 3'd1}), 1'b0);
    step();
    expect_result("multi", 1'b1, 1);
`ifdef LOOKUP_MULTIHIT_CHK_EN
    check("multi_flag", 32'(multi_hit), 32'd1);
`else
    check("multi_flag", 32'(multi_hit), 32'd0);
`endif
    drive(1'b1, 3'd2, 3'd4, store({1'b1, 3'd6}, {1'b1, 3'd2}, {1'b1, 3'd6}, {1'b1, 3'd1}), 1'b0);
    step();
    expect_result("single", 1'b1, 2);
    check("single_flag", 32'(multi_hit), 32'd0);

    // Asynchronous reset in the middle of operation
    drive(1'b1, 3'd5, 3'd6, allv, 1'b0);
    step();
    drive(1'b0, 3'd5, 3'd6, allv, 1'b0);
    check("pre_arst_valid", 32'(lookup_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(lookup_valid), 32'd0);
    check("arst_sel",   32'(way_select),   32'd0);
    check("arst_idx",   32'(way_idx),      32'd0);
    reset_n = 1'b1;
    step();
    drive(1'b1, 3'd5, 3'd6, allv, 1'b0);
    step();
    expect_result("arst_set6", 1'b0, 0);
    drive(1'b0, 3'd0, 3'd0, allv, 1'b0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
